// File: rtl/cdb_arbiter_if.sv
// Result-offer and CDB broadcast bundle for cdb_arbiter.
// master: the side that offers results and watches the CDB; slave: the arbiter.
interface cdb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rob_id;
  logic [31:0] alu_val;
  logic        alu_full;
  logic        lsb_valid;
  logic [4:0]  lsb_rob_id;
  logic [31:0] lsb_val;
  logic        lsb_full;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_val;
  logic        cdb_src;

  modport master (
    output alu_valid, alu_rob_id, alu_val, lsb_valid, lsb_rob_id, lsb_val,
    input  alu_full, lsb_full, cdb_valid, cdb_rob_id, cdb_val, cdb_src
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_val, lsb_valid, lsb_rob_id, lsb_val,
    output alu_full, lsb_full, cdb_valid, cdb_rob_id, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs (ALU, LSB) merged onto one registered CDB.
// Define CDB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority, LSB over ALU.
module cdb_arbiter #(
  parameter int unsigned FIFO_DEPTH_BIT = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear_flag,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BIT;

  typedef logic [FIFO_DEPTH_BIT-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_BIT:0]   cnt_t;

  localparam ptr_t PtrOne  = ptr_t'(1);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam cnt_t CntFull = cnt_t'(Depth);

  typedef enum logic {GrantAlu = 1'b0, GrantLsb = 1'b1} grant_e;

  logic [4:0]  alu_rob_q [Depth];
  logic [31:0] alu_val_q [Depth];
  logic [4:0]  lsb_rob_q [Depth];
  logic [31:0] lsb_val_q [Depth];

  ptr_t   alu_rd_q, alu_wr_q, lsb_rd_q, lsb_wr_q;
  cnt_t   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  grant_e last_grant_q;
  logic   cdb_valid_q;
  logic [4:0]  cdb_rob_id_q;
  logic [31:0] cdb_val_q;
  grant_e cdb_src_q;

  logic alu_full, lsb_full, alu_ne, lsb_ne;
  logic push_alu, push_lsb, pop_alu, pop_lsb, grant_lsb;

  // Full looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign alu_full = (alu_cnt_q == CntFull);
  assign lsb_full = (lsb_cnt_q == CntFull);
  assign alu_ne   = (alu_cnt_q != '0);
  assign lsb_ne   = (lsb_cnt_q != '0);

  assign push_alu = bus.alu_valid && !alu_full && rdy_in && !clear_flag;
  assign push_lsb = bus.lsb_valid && !lsb_full && rdy_in && !clear_flag;

`ifdef CDB_ROUND_ROBIN_EN
  assign grant_lsb = lsb_ne && (!alu_ne || (last_grant_q == GrantAlu));
`else
  assign grant_lsb = lsb_ne;
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign pop_lsb = grant_lsb;
  assign pop_alu = alu_ne && !grant_lsb;

  always_comb begin
    alu_cnt_d = alu_cnt_q;
    case ({push_alu, pop_alu})
      2'b10:   alu_cnt_d = alu_cnt_q + CntOne;
      2'b01:   alu_cnt_d = alu_cnt_q - CntOne;
      default: alu_cnt_d = alu_cnt_q;
    endcase
    lsb_cnt_d = lsb_cnt_q;
    case ({push_lsb, pop_lsb})
      2'b10:   lsb_cnt_d = lsb_cnt_q + CntOne;
      2'b01:   lsb_cnt_d = lsb_cnt_q - CntOne;
      default: lsb_cnt_d = lsb_cnt_q;
    endcase
  end

  // Payload storage needs no reset: entries are only visible through the counts.
  always_ff @(posedge clk_in) begin
    if (push_alu) begin
      alu_rob_q[alu_wr_q] <= bus.alu_rob_id;
      alu_val_q[alu_wr_q] <= bus.alu_val;
    end
    if (push_lsb) begin
      lsb_rob_q[lsb_wr_q] <= bus.lsb_rob_id;
      lsb_val_q[lsb_wr_q] <= bus.lsb_val;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_rd_q     <= '0;
      alu_wr_q     <= '0;
      alu_cnt_q    <= '0;
      lsb_rd_q     <= '0;
      lsb_wr_q     <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= GrantAlu;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= GrantAlu;
    end else if (clear_flag) begin
      alu_rd_q     <= '0;
      alu_wr_q     <= '0;
      alu_cnt_q    <= '0;
      lsb_rd_q     <= '0;
      lsb_wr_q     <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= GrantAlu;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= GrantAlu;
    end else if (rdy_in) begin
      if (push_alu) alu_wr_q <= alu_wr_q + PtrOne;
      if (pop_alu)  alu_rd_q <= alu_rd_q + PtrOne;
      if (push_lsb) lsb_wr_q <= lsb_wr_q + PtrOne;
      if (pop_lsb)  lsb_rd_q <= lsb_rd_q + PtrOne;
      alu_cnt_q <= alu_cnt_d;
      lsb_cnt_q <= lsb_cnt_d;
      if (pop_lsb) begin
        cdb_valid_q  <= 1'b1;
        cdb_rob_id_q <= lsb_rob_q[lsb_rd_q];
        cdb_val_q    <= lsb_val_q[lsb_rd_q];
        cdb_src_q    <= GrantLsb;
        last_grant_q <= GrantLsb;
      end else if (pop_alu) begin
        cdb_valid_q  <= 1'b1;
        cdb_rob_id_q <= alu_rob_q[alu_rd_q];
        cdb_val_q    <= alu_val_q[alu_rd_q];
        cdb_src_q    <= GrantAlu;
        last_grant_q <= GrantAlu;
      end else begin
        cdb_valid_q  <= 1'b0;
        cdb_rob_id_q <= '0;
        cdb_val_q    <= '0;
        cdb_src_q    <= GrantAlu;
      end
    end
  end

  assign bus.alu_full   = alu_full;
  assign bus.lsb_full   = lsb_full;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_val    = cdb_val_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter at depth 2; expectations follow the build's arbitration mode.
module tb_cdb_arbiter;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_flag;

  cdb_arbiter_if bus ();

  cdb_arbiter #(
    .FIFO_DEPTH_BIT(1)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_flag (clear_flag),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [37:0] seen [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vv(input logic [4:0] r);
    return 32'hC0DE_0000 | {27'd0, r};
  endfunction

  task automatic check_cdb(input string tag, input logic v, input logic s, input logic [4:0] r,
                           input logic [31:0] val);
    check_eq(tag, {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_id, bus.cdb_val}, {v, s, r, val});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic lv, input logic [4:0] lr);
    bus.alu_valid  = av;
    bus.alu_rob_id = ar;
    bus.alu_val    = vv(ar);
    bus.lsb_valid  = lv;
    bus.lsb_rob_id = lr;
    bus.lsb_val    = vv(lr);
  endtask

  task automatic sample();
    if (bus.cdb_valid) seen.push_back({bus.cdb_src, bus.cdb_rob_id, bus.cdb_val});
  endtask

  initial begin
    logic [4:0] exp_rob [8];
    logic [4:0] exp3 [6];
    int ai, li, n_alu;

    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_flag = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    #12;
    check_cdb("reset_cdb", 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("reset_fulls", {bus.alu_full, bus.lsb_full}, 2'b00);
    rst_in = 1'b0;

    // Single ALU result: pushed at edge 1, broadcast at edge 2, gone at edge 3.
    bus.alu_valid  = 1'b1;
    bus.alu_rob_id = 5'd3;
    bus.alu_val    = 32'h11;
    tick();
    check_cdb("t1_no_bypass", 1'b0, 1'b0, 5'd0, 32'd0);
    bus.alu_valid = 1'b0;
    tick();
    check_cdb("t1_bcast", 1'b1, 1'b0, 5'd3, 32'h11);
    tick();
    check_cdb("t1_idle", 1'b0, 1'b0, 5'd0, 32'd0);

    // Both sources stream four results each, offering only while not full.
    seen.delete();
    ai = 0;
    li = 0;
    for (int c = 0; c < 14; c++) begin
      drive((ai < 4) && !bus.alu_full, 5'(ai + 1), (li < 4) && !bus.lsb_full, 5'(li + 9));
      @(posedge clk_in);
      if (bus.alu_valid) ai++;
      if (bus.lsb_valid) li++;
      #1;
      sample();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
`ifdef CDB_ROUND_ROBIN_EN
    exp_rob = '{5'd9, 5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4};
`else
    exp_rob = '{5'd9, 5'd10, 5'd11, 5'd12, 5'd1, 5'd2, 5'd3, 5'd4};
`endif
    check_eq("t2_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      check_eq($sformatf("t2_bcast%0d", i), seen[i],
               {exp_rob[i] >= 5'd9, exp_rob[i], vv(exp_rob[i])});
    end
    check_eq("t2_drained_fulls", {bus.alu_full, bus.lsb_full}, 2'b00);

`ifndef CDB_ROUND_ROBIN_EN
    // LSB traffic keeps the CDB busy; third ALU offer lands on a full FIFO and is dropped.
    seen.delete();
    drive(1'b0, 5'd0, 1'b1, 5'd20);
    tick();
    sample();
    drive(1'b1, 5'd5, 1'b1, 5'd21);
    tick();
    sample();
    drive(1'b1, 5'd6, 1'b1, 5'd22);
    tick();
    sample();
    check_eq("t3_full_after_2", bus.alu_full, 1'b1);
    drive(1'b1, 5'd7, 1'b1, 5'd23);
    tick();
    sample();
    check_eq("t3_full_held", bus.alu_full, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    repeat (6) begin
      tick();
      sample();
    end
    exp3 = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd5, 5'd6};
    n_alu = 0;
    foreach (seen[i]) if (!seen[i][37]) n_alu++;
    check_eq("t3_alu_bcasts", 64'(n_alu), 64'd2);
    check_eq("t3_count", 64'(seen.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      check_eq($sformatf("t3_bcast%0d", i), seen[i], {exp3[i] >= 5'd20, exp3[i], vv(exp3[i])});
    end
`endif

    // Flush with entries buffered and a same-edge LSB offer.
    drive(1'b1, 5'd30, 1'b1, 5'd14);
    tick();
    drive(1'b1, 5'd31, 1'b1, 5'd15);
    tick();
    check_cdb("t4_pre_clear", 1'b1, 1'b1, 5'd14, vv(5'd14));
    check_eq("t4_pre_alu_full", bus.alu_full, 1'b1);
    drive(1'b0, 5'd0, 1'b1, 5'd16);
    clear_flag = 1'b1;
    tick();
    clear_flag = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check_cdb("t4_cleared", 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("t4_fulls", {bus.alu_full, bus.lsb_full}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cdb($sformatf("t4_idle%0d", i), 1'b0, 1'b0, 5'd0, 32'd0);
    end

    // Freeze with a broadcast on the bus and an ALU entry queued.
    drive(1'b1, 5'd17, 1'b1, 5'd18);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    check_cdb("t5_pre_freeze", 1'b1, 1'b1, 5'd18, vv(5'd18));
    rdy_in = 1'b0;
    drive(1'b1, 5'd19, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cdb($sformatf("t5_frozen%0d", i), 1'b1, 1'b1, 5'd18, vv(5'd18));
      check_eq($sformatf("t5_frozen_full%0d", i), bus.alu_full, 1'b0);
    end
    rdy_in = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    check_cdb("t5_resume", 1'b1, 1'b0, 5'd17, vv(5'd17));
    tick();
    check_cdb("t5_after", 1'b0, 1'b0, 5'd0, 32'd0);

    // Asynchronous reset in mid-traffic discards everything buffered.
    drive(1'b1, 5'd24, 1'b1, 5'd25);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    check_cdb("t6_pre_reset", 1'b1, 1'b1, 5'd25, vv(5'd25));
    #2;
    rst_in = 1'b1;
    #1;
    check_cdb("t6_async_reset", 1'b0, 1'b0, 5'd0, 32'd0);
    check_eq("t6_fulls", {bus.alu_full, bus.lsb_full}, 2'b00);
    #1;
    rst_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_cdb($sformatf("t6_post%0d", i), 1'b0, 1'b0, 5'd0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
